scb_stable_mc: RTL and testbench

// - Multi-issue, multi-writeback scoreboard for fixed-latency (stable) execution pipes.
// - Sits between reservation stations and ROB fill: grants issue only when a writeback lane
//   is free in the completion cycle, then emits {pipe, preg} to ROB exactly LAT cycles later.
// - Successor to single-issue/single-fill SCB: N_ISS channels, N_WB lanes, per-pipe latency param.

---
 rtl/scb_stable_mc_pkg.sv | 26 ++
 rtl/scb_stable_mc_if.sv | 30 +++
 rtl/scb_stable_mc_lane_alloc.sv | 29 ++
 rtl/scb_stable_mc.sv | 156 +++++++++++++++
 tb/tb_scb_stable_mc.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/scb_stable_mc_pkg.sv
// Shared types and widths for the fixed-latency multi-issue scoreboard.
// The calendar entry layout lives here so the top and any debug tooling agree on it.
package scb_stable_pkg;

  localparam int SCB_BL_PIPE = 2;
  localparam int SCB_BL_PREG = 6;
  localparam int LAT_FIELD_W = 4;

  localparam logic [SCB_BL_PIPE-1:0] PIPE_NONE = '0;

  typedef struct packed {
    logic                   valid;
    logic [SCB_BL_PIPE-1:0] pipe;
    logic [SCB_BL_PREG-1:0] preg;
  } scb_ent_t;

  localparam scb_ent_t ENT_EMPTY = '0;

  function automatic int unsigned ones(input logic [31:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < 32; i++) n += {31'b0, v[i]};
    return n;
  endfunction

endpackage

// File: rtl/scb_stable_mc_if.sv
// Issue and writeback bundle between reservation stations, scoreboard and ROB fill.
// Channel k / lane w occupy slice [k*W +: W] of each flattened vector.
interface scb_stable_mc_if
  import scb_stable_pkg::*;
#(
  parameter int N_ISS   = 2,
  parameter int N_WB    = 2,
  parameter int BL_PIPE = SCB_BL_PIPE,
  parameter int BL_PREG = SCB_BL_PREG
);

  logic [N_ISS-1:0]         iss_req;
  logic [N_ISS*BL_PIPE-1:0] iss_pipe;
  logic [N_ISS*BL_PREG-1:0] iss_preg;
  logic [N_ISS-1:0]         iss_gnt;
  logic [N_WB-1:0]          wb_valid;
  logic [N_WB*BL_PIPE-1:0]  wb_pipe;
  logic [N_WB*BL_PREG-1:0]  wb_preg;

  modport master (
    output iss_req, iss_pipe, iss_preg,
    input  iss_gnt, wb_valid, wb_pipe, wb_preg
  );

  modport slave (
    input  iss_req, iss_pipe, iss_preg,
    output iss_gnt, wb_valid, wb_pipe, wb_preg
  );

endinterface

// File: rtl/scb_stable_mc_lane_alloc.sv
// Picks lanes for up to N_ISS inserts into one calendar slot: request i gets the
// i-th lowest free lane. The grant logic guarantees count never exceeds the free lanes.
module scb_lane_alloc #(
  parameter  int N_WB  = 2,
  parameter  int N_ISS = 2,
  localparam int CW    = $clog2(N_ISS + 1)
) (
  input  logic [N_WB-1:0]             free,
  input  logic [CW-1:0]               count,
  output logic [N_ISS-1:0][N_WB-1:0]  lanes
);

  always_comb begin
    logic [N_WB-1:0] avail;
    avail = free;
    lanes = '0;
    for (int i = 0; i < N_ISS; i++) begin
      if (i < int'(count)) begin
        for (int w = 0; w < N_WB; w++) begin
          if (avail[w] && (lanes[i] == '0)) begin
            lanes[i][w] = 1'b1;
            avail[w]    = 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: rtl/scb_stable_mc.sv
// Multi-issue scoreboard for fixed-latency pipes: grants issue only when a writeback
// lane is free in the completion cycle, then emits {pipe, preg} exactly LAT cycles later.
module scb_stable_mc
  import scb_stable_pkg::*;
#(
  parameter  int N_PIPE  = 4,
  parameter  int BL_PIPE = SCB_BL_PIPE,
  parameter  int BL_PREG = SCB_BL_PREG,
  parameter  int MAX_LAT = 8,
  parameter  int N_ISS   = 2,
  parameter  int N_WB    = 2,
  parameter  logic [N_PIPE*LAT_FIELD_W-1:0] PIPE_LAT = {N_PIPE{4'd1}},
  localparam int CNT_W   = $clog2(MAX_LAT * N_WB + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  scb_stable_mc_if.slave   bus,
  output logic [CNT_W-1:0] inflight,
  output logic             idle
);

  localparam int ISS_CW = $clog2(N_ISS + 1);

  function automatic logic [2**BL_PIPE-1:0] mk_pipe_ok();
    logic [2**BL_PIPE-1:0] m;
    m = '0;
    for (int i = 0; i < 2**BL_PIPE; i++)
      m[i] = (i < N_PIPE) && (BL_PIPE'(i) != PIPE_NONE);
    return m;
  endfunction

  localparam logic [2**BL_PIPE-1:0] PIPE_OK = mk_pipe_ok();

  if (BL_PIPE != SCB_BL_PIPE || BL_PREG != SCB_BL_PREG) begin : g_bad_width
    $error("scb_stable_mc: BL_PIPE/BL_PREG must match scb_stable_pkg");
  end
  if (N_WB < 1 || N_ISS < 1) begin : g_bad_count
    $error("scb_stable_mc: N_WB and N_ISS must be >= 1");
  end
  for (genvar p = 1; p < N_PIPE; p++) begin : g_lat_chk
    if (int'(PIPE_LAT[p*LAT_FIELD_W +: LAT_FIELD_W]) < 1 ||
        int'(PIPE_LAT[p*LAT_FIELD_W +: LAT_FIELD_W]) > MAX_LAT) begin : g_bad_lat
      $error("scb_stable_mc: PIPE_LAT out of range 1..MAX_LAT");
    end
  end

  // slot[d] holds the entries that complete d cycles from now
  scb_ent_t                   slot     [1:MAX_LAT][N_WB];
  scb_ent_t                   shifted  [1:MAX_LAT][N_WB];
  scb_ent_t                   slot_nxt [1:MAX_LAT][N_WB];
  logic [N_WB-1:0]            free_mask[1:MAX_LAT];
  int unsigned                free_cnt [1:MAX_LAT];
  int unsigned                taken    [1:MAX_LAT];
  logic [ISS_CW-1:0]          req_cnt  [1:MAX_LAT];
  logic [N_ISS-1:0][N_WB-1:0] alloc    [1:MAX_LAT];

  logic [BL_PIPE-1:0] pipe_k [N_ISS];
  logic [BL_PREG-1:0] preg_k [N_ISS];
  int                 lat_k  [N_ISS];
  int                 rank_k [N_ISS];
  logic [N_ISS-1:0]   gnt;
  logic [CNT_W-1:0]   inflight_nxt;

  // Lanes free in slot[d] after the shift are those empty in slot[d+1] today.
  for (genvar d = 1; d <= MAX_LAT; d++) begin : g_slot
    for (genvar w = 0; w < N_WB; w++) begin : g_lane
      if (d == MAX_LAT) begin : g_top
        assign free_mask[d][w] = 1'b1;
        assign shifted[d][w]   = ENT_EMPTY;
      end else begin : g_mid
        assign free_mask[d][w] = ~slot[d+1][w].valid;
        assign shifted[d][w]   = slot[d+1][w];
      end
    end
    assign free_cnt[d] = ones(32'(free_mask[d]));
    assign req_cnt[d]  = ISS_CW'(taken[d]);

    scb_lane_alloc #(.N_WB(N_WB), .N_ISS(N_ISS)) u_alloc (
      .free  (free_mask[d]),
      .count (req_cnt[d]),
      .lanes (alloc[d])
    );
  end

  // Channel 0 has strict priority; each later channel sees the lanes and pipes
  // already claimed by lower channels in this same cycle.
  always_comb begin
    gnt = '0;
    for (int d = 1; d <= MAX_LAT; d++) taken[d] = 0;
    for (int k = 0; k < N_ISS; k++) begin
      logic dup;
      pipe_k[k] = bus.iss_pipe[k*BL_PIPE +: BL_PIPE];
      preg_k[k] = bus.iss_preg[k*BL_PREG +: BL_PREG];
      lat_k[k]  = PIPE_OK[pipe_k[k]]
                ? int'(PIPE_LAT[int'(pipe_k[k])*LAT_FIELD_W +: LAT_FIELD_W]) : 1;
      rank_k[k] = 0;
      dup       = 1'b0;
      for (int j = 0; j < k; j++)
        if (gnt[j] && (pipe_k[j] == pipe_k[k])) dup = 1'b1;
      if (bus.iss_req[k] && PIPE_OK[pipe_k[k]] && !clear && !dup &&
          (free_cnt[lat_k[k]] > taken[lat_k[k]])) begin
        gnt[k]              = 1'b1;
        rank_k[k]           = int'(taken[lat_k[k]]);
        taken[lat_k[k]]     = taken[lat_k[k]] + 1;
      end
    end
  end

  always_comb begin
    slot_nxt = shifted;
    for (int k = 0; k < N_ISS; k++) begin
      if (gnt[k]) begin
        for (int w = 0; w < N_WB; w++) begin
          if (alloc[lat_k[k]][rank_k[k]][w])
            slot_nxt[lat_k[k]][w] = '{valid: 1'b1, pipe: pipe_k[k], preg: preg_k[k]};
        end
      end
    end
  end

  always_comb begin
    int n;
    n = int'(inflight);
    for (int w = 0; w < N_WB; w++) if (slot[1][w].valid) n = n - 1;
    for (int k = 0; k < N_ISS; k++) if (gnt[k]) n = n + 1;
    inflight_nxt = CNT_W'(n);
  end

  // NOTE: the calendar is flops, not RAM -- every slot resets so no stale valid
  // bit can complete after a reset or flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int d = 1; d <= MAX_LAT; d++)
        for (int w = 0; w < N_WB; w++) slot[d][w] <= ENT_EMPTY;
      inflight <= '0;
    end else if (clear) begin
      for (int d = 1; d <= MAX_LAT; d++)
        for (int w = 0; w < N_WB; w++) slot[d][w] <= ENT_EMPTY;
      inflight <= '0;
    end else begin
      slot     <= slot_nxt;
      inflight <= inflight_nxt;
    end
  end

  for (genvar w = 0; w < N_WB; w++) begin : g_wb
    assign bus.wb_valid[w]                  = slot[1][w].valid;
    assign bus.wb_pipe[w*BL_PIPE +: BL_PIPE] = slot[1][w].pipe;
    assign bus.wb_preg[w*BL_PREG +: BL_PREG] = slot[1][w].preg;
  end

  assign bus.iss_gnt = gnt;
  assign idle        = (inflight == '0);

endmodule

// File: tb/tb_scb_stable_mc.sv
// Directed bench for scb_stable_mc with latencies p1=2, p2=2, p3=3.
// Inputs change 1ns after posedge; outputs are compared at the negedge.
module tb_scb_stable_mc;
  import scb_stable_pkg::*;

  localparam int N_PIPE  = 4;
  localparam int BL_PIPE = 2;
  localparam int BL_PREG = 6;
  localparam int MAX_LAT = 8;
  localparam int N_ISS   = 2;
  localparam int N_WB    = 2;
  localparam logic [15:0] LATS = {4'd3, 4'd2, 4'd2, 4'd1};

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       clear = 1'b0;
  logic [4:0] inflight;
  logic       idle;

  int n_checks = 0;
  int n_pass   = 0;

  scb_stable_mc_if #(.N_ISS(N_ISS), .N_WB(N_WB), .BL_PIPE(BL_PIPE), .BL_PREG(BL_PREG)) bus ();

  scb_stable_mc #(
    .N_PIPE(N_PIPE), .BL_PIPE(BL_PIPE), .BL_PREG(BL_PREG), .MAX_LAT(MAX_LAT),
    .N_ISS(N_ISS), .N_WB(N_WB), .PIPE_LAT(LATS)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (clear),
    .bus      (bus),
    .inflight (inflight),
    .idle     (idle)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic no_req();
    bus.iss_req  = '0;
    bus.iss_pipe = '0;
    bus.iss_preg = '0;
  endtask

  task automatic issue(input int ch, input logic [1:0] pipe, input logic [5:0] preg);
    bus.iss_req[ch]          = 1'b1;
    bus.iss_pipe[ch*2 +: 2]  = pipe;
    bus.iss_preg[ch*6 +: 6]  = preg;
  endtask

  initial begin
    logic [1:0] seen;
    no_req();
    repeat (2) @(posedge clk);
    #1;
    check("rst_wb_valid", 32'(bus.wb_valid), 32'h0);
    check("rst_wb_pipe",  32'(bus.wb_pipe),  32'h0);
    check("rst_wb_preg",  32'(bus.wb_preg),  32'h0);
    check("rst_inflight", 32'(inflight),     32'h0);
    check("rst_idle",     32'(idle),         32'h1);
    mid();
    rst_n = 1'b1;

    // Async reset with three entries in flight
    tick(); issue(0, 2'd3, 6'd1); issue(1, 2'd1, 6'd2);
    mid();  check("ar_gnt_t0", 32'(bus.iss_gnt), 32'h3);
    tick(); no_req(); issue(0, 2'd2, 6'd3);
    mid();  check("ar_gnt_t1", 32'(bus.iss_gnt), 32'h1);
            check("ar_infl_t1", 32'(inflight), 32'd2);
    tick(); no_req();
    mid();  check("ar_infl_t2", 32'(inflight), 32'd3);
            check("ar_wb_t2", 32'(bus.wb_valid), 32'h1);
            check("ar_preg_t2", 32'(bus.wb_preg), 32'd2);
    #1 rst_n = 1'b0;
    #1;
    check("ar_wb_async",   32'(bus.wb_valid), 32'h0);
    check("ar_infl_async", 32'(inflight),     32'h0);
    check("ar_idle_async", 32'(idle),         32'h1);
    mid();
    rst_n = 1'b1;
    seen = '0;
    for (int c = 0; c < 5; c++) begin
      tick(); mid();
      seen |= bus.wb_valid;
    end
    check("ar_no_late_wb", 32'(seen), 32'h0);

    // Single issue on pipe3, latency 3
    tick(); issue(0, 2'd3, 6'd5);
    mid();  check("s_gnt", 32'(bus.iss_gnt), 32'h1);
    tick(); no_req();
    mid();  check("s_infl_t1", 32'(inflight), 32'd1);
    tick(); mid();
            check("s_wb_t2", 32'(bus.wb_valid), 32'h0);
    tick(); mid();
            check("s_wb_t3",   32'(bus.wb_valid), 32'h1);
            check("s_pipe_t3", 32'(bus.wb_pipe),  32'h3);
            check("s_preg_t3", 32'(bus.wb_preg),  32'd5);
            check("s_infl_t3", 32'(inflight),     32'd1);
    tick(); mid();
            check("s_wb_t4",   32'(bus.wb_valid), 32'h0);
            check("s_infl_t4", 32'(inflight),     32'd0);
            check("s_idle_t4", 32'(idle),         32'h1);

    // Lane conflict: only one free lane in the completion slot
    tick(); issue(0, 2'd3, 6'd7);
    mid();  check("lc_gnt_t0", 32'(bus.iss_gnt), 32'h1);
    tick(); no_req(); issue(0, 2'd1, 6'd1); issue(1, 2'd2, 6'd2);
    mid();  check("lc_gnt_t1", 32'(bus.iss_gnt), 32'h1);
    tick(); no_req(); issue(0, 2'd2, 6'd2);
    mid();  check("lc_gnt_t2", 32'(bus.iss_gnt), 32'h1);
    tick(); no_req();
    mid();  check("lc_wb_t3",   32'(bus.wb_valid), 32'h3);
            check("lc_pipe_t3", 32'(bus.wb_pipe),  32'h7);
            check("lc_preg_t3", 32'(bus.wb_preg),  32'h047);
    tick(); mid();
            check("lc_wb_t4",   32'(bus.wb_valid), 32'h1);
            check("lc_pipe_t4", 32'(bus.wb_pipe),  32'h2);
            check("lc_preg_t4", 32'(bus.wb_preg),  32'h002);
    tick(); mid();
            check("lc_idle_t5", 32'(idle), 32'h1);

    // Two channels, different pipes, same latency, empty slot: both granted
    tick(); issue(0, 2'd1, 6'd12); issue(1, 2'd2, 6'd13);
    mid();  check("dual_gnt", 32'(bus.iss_gnt), 32'h3);
    tick(); no_req();
    tick(); mid();
            check("dual_wb",   32'(bus.wb_valid), 32'h3);
            check("dual_pipe", 32'(bus.wb_pipe),  32'h9);
            check("dual_preg", 32'(bus.wb_preg),  32'h34C);

    // Same pipe on both channels: only channel 0
    tick(); issue(0, 2'd1, 6'd9); issue(1, 2'd1, 6'd10);
    mid();  check("sp_gnt", 32'(bus.iss_gnt), 32'h1);
    tick(); no_req();
    tick(); mid();
            check("sp_wb",   32'(bus.wb_valid), 32'h1);
            check("sp_preg", 32'(bus.wb_preg),  32'd9);
    tick(); mid();
            check("sp_idle", 32'(idle), 32'h1);

    // Clear kills a pending completion and blocks same-cycle grants
    tick(); issue(0, 2'd3, 6'd4);
    mid();  check("cl_gnt_t0", 32'(bus.iss_gnt), 32'h1);
    tick(); clear = 1'b1; no_req(); issue(0, 2'd1, 6'd6);
    mid();  check("cl_gnt_t1",  32'(bus.iss_gnt), 32'h0);
            check("cl_infl_t1", 32'(inflight),    32'd1);
    tick(); clear = 1'b0; no_req();
    mid();  check("cl_infl_t2", 32'(inflight), 32'd0);
            check("cl_idle_t2", 32'(idle),     32'h1);
    tick(); mid();
            check("cl_wb_t3", 32'(bus.wb_valid), 32'h0);

    // Clear still shows the completion already in the output slot
    tick(); issue(0, 2'd1, 6'd11);
    mid();  check("clw_gnt", 32'(bus.iss_gnt), 32'h1);
    tick(); no_req();
    tick(); clear = 1'b1;
    mid();  check("clw_wb",   32'(bus.wb_valid), 32'h1);
            check("clw_preg", 32'(bus.wb_preg),  32'd11);
    tick(); clear = 1'b0;
    mid();  check("clw_wb_after",   32'(bus.wb_valid), 32'h0);
            check("clw_infl_after", 32'(inflight),     32'd0);

    // Pipe id 0 is never granted
    tick(); issue(0, 2'd0, 6'd3); issue(1, 2'd0, 6'd4);
    mid();  check("p0_gnt", 32'(bus.iss_gnt), 32'h0);
    tick(); no_req();
    mid();  check("p0_infl", 32'(inflight), 32'd0);

    // Back-to-back pipe1 issue for 10 cycles: one completion per cycle
    for (int c = 0; c <= 12; c++) begin
      int g;
      int p;
      tick(); no_req();
      if (c < 10) issue(0, 2'd1, 6'(20 + c));
      mid();
      g = (c < 10) ? c : 10;
      p = (c <= 2) ? 0 : ((c - 2 < 10) ? c - 2 : 10);
      check($sformatf("st_gnt_c%0d", c), 32'(bus.iss_gnt), (c < 10) ? 32'h1 : 32'h0);
      check($sformatf("st_wb_c%0d", c), 32'(bus.wb_valid),
            (c >= 2 && c <= 11) ? 32'h1 : 32'h0);
      check($sformatf("st_infl_c%0d", c), 32'(inflight), 32'(g - p));
      if (c >= 2 && c <= 11)
        check($sformatf("st_preg_c%0d", c), 32'(bus.wb_preg), 32'(20 + c - 2));
    end
    check("st_idle_end", 32'(idle), 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
